reset_sequencer: RTL



---
 rtl/reset_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/reset_sequencer.sv
// Reset sequencer: synchronises the board reset, holds every downstream reset for a
// programmable time, then releases the channels one by one, bit 0 first, with a fixed gap
// between channels. A software reset request or a CPU trap re-runs the whole sequence.
// Restarts that leave RUN are counted (saturating) and their cause is recorded.
module reset_sequencer #(
    parameter int unsigned N_CH        = 3,
    parameter int unsigned HOLD_CYCLES = 65536,
    parameter int unsigned STAGE_GAP   = 16,
    parameter int unsigned SYNC_STAGES = 2,
    parameter bit          TRAP_RST_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            soft_rst_req,
    input  logic            trap,
    output logic [N_CH-1:0] rst_out,
    output logic            all_released,
    output logic [7:0]      rst_count,
    output logic [1:0]      last_cause
);

    localparam int unsigned CNT_W = $clog2(HOLD_CYCLES + 1);
    localparam int unsigned GAP_W = $clog2(STAGE_GAP + 1);
    localparam int unsigned IDX_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    localparam logic [CNT_W-1:0] HoldInit = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [GAP_W-1:0] GapInit  = GAP_W'(STAGE_GAP - 1);
    localparam logic [IDX_W-1:0] IdxLast  = IDX_W'(N_CH - 1);

    typedef enum logic [1:0] {
        StAssert,
        StRelease,
        StRun
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_rst;
    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [GAP_W-1:0]       gap_q;
    logic [IDX_W-1:0]       idx_q;
    logic [IDX_W-1:0]       idx_next;
    logic [N_CH-1:0]        rst_out_q;
    logic                   all_released_q;
    logic [7:0]             rst_count_q;
    logic [1:0]             last_cause_q;
    logic                   restart;

    assign sync_rst = sync_q[SYNC_STAGES-1];
    assign restart  = soft_rst_req | (TRAP_RST_EN & trap);
    assign idx_next = idx_q + 1'b1;

    // Release synchroniser: asserts asynchronously, deasserts after SYNC_STAGES edges.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], 1'b0};
        end
    end

    // Sequencing FSM with registered outputs and restart bookkeeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StAssert;
            cnt_q          <= HoldInit;
            gap_q          <= GapInit;
            idx_q          <= '0;
            rst_out_q      <= '1;
            all_released_q <= 1'b0;
            rst_count_q    <= '0;
            last_cause_q   <= 2'd0;
        end else if (sync_rst) begin
            // Board reset still settling: park everything at its reset value.
            state_q        <= StAssert;
            cnt_q          <= HoldInit;
            gap_q          <= GapInit;
            idx_q          <= '0;
            rst_out_q      <= '1;
            all_released_q <= 1'b0;
            rst_count_q    <= '0;
            last_cause_q   <= 2'd0;
        end else if (restart) begin
            // Only restarts out of RUN are real reset events; earlier ones just extend the hold.
            if (state_q == StRun) begin
                if (rst_count_q != 8'hFF) begin
                    rst_count_q <= rst_count_q + 8'd1;
                end
                last_cause_q <= soft_rst_req ? 2'd1 : 2'd2;
            end
            state_q        <= StAssert;
            cnt_q          <= HoldInit;
            gap_q          <= GapInit;
            idx_q          <= '0;
            rst_out_q      <= '1;
            all_released_q <= 1'b0;
        end else begin
            case (state_q)
                StAssert: begin
                    if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end else begin
                        // Channels release from the bottom up, so a left shift clears the next one.
                        rst_out_q <= rst_out_q << 1;
                        if (N_CH == 1) begin
                            state_q        <= StRun;
                            all_released_q <= 1'b1;
                        end else begin
                            idx_q   <= '0;
                            gap_q   <= GapInit;
                            state_q <= StRelease;
                        end
                    end
                end
                StRelease: begin
                    if (gap_q != '0) begin
                        gap_q <= gap_q - 1'b1;
                    end else begin
                        rst_out_q <= rst_out_q << 1;
                        idx_q     <= idx_next;
                        gap_q     <= GapInit;
                        if (idx_next == IdxLast) begin
                            state_q        <= StRun;
                            all_released_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    rst_out_q      <= '0;
                    all_released_q <= 1'b1;
                end
                default: begin
                    state_q   <= StAssert;
                    cnt_q     <= HoldInit;
                    rst_out_q <= '1;
                end
            endcase
        end
    end

    assign rst_out      = rst_out_q;
    assign all_released = all_released_q;
    assign rst_count    = rst_count_q;
    assign last_cause   = last_cause_q;

endmodule
